// File: rtl/maxpool_seq.sv
// Running-max pooling sequencer: one max per window of win_len beats, num_win windows per job.
// Latency: out_valid rises the cycle after the last beat of a window transfers.
// Backpressure: in_ready drops while a result waits; out_data/out_valid hold until out_ready.
module maxpool_seq #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4,
    parameter int NWIN_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clear,
    input  logic [LEN_W-1:0]  win_len,
    input  logic [NWIN_W-1:0] num_win,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, OUT = 2'd2} state_t;

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  len_r, elem_cnt;
    logic [NWIN_W-1:0] nwin_r, win_cnt;
    logic [DATA_W-1:0] acc, beat_max;
    logic              beat, first_beat, last_beat, last_win;

    assign in_ready   = (state == ACCUM);
    assign beat       = in_valid & in_ready;
    assign first_beat = (elem_cnt == '0);
    assign last_beat  = beat && (elem_cnt == len_r - LEN_W'(1));
    assign last_win   = (win_cnt == nwin_r - NWIN_W'(1));
    // First beat of a window loads directly so a stale max from the previous window never leaks in.
    assign beat_max   = (first_beat || (in_data > acc)) ? in_data : acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = ACCUM;
                ACCUM:   if (last_beat) state_nxt = OUT;
                OUT:     if (out_ready) state_nxt = last_win ? IDLE : ACCUM;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_r     <= '0;
            nwin_r    <= '0;
            elem_cnt  <= '0;
            win_cnt   <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                elem_cnt  <= '0;
                win_cnt   <= '0;
                acc       <= '0;
                out_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            // A zero field would never terminate, so it is treated as one.
                            len_r    <= (win_len == '0) ? LEN_W'(1) : win_len;
                            nwin_r   <= (num_win == '0) ? NWIN_W'(1) : num_win;
                            elem_cnt <= '0;
                            win_cnt  <= '0;
                            busy     <= 1'b1;
                        end
                    end
                    ACCUM: begin
                        if (beat) begin
                            acc <= beat_max;
                            if (last_beat) begin
                                out_data  <= beat_max;
                                out_valid <= 1'b1;
                                elem_cnt  <= '0;
                            end else begin
                                elem_cnt <= elem_cnt + LEN_W'(1);
                            end
                        end
                    end
                    OUT: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            if (last_win) begin
                                win_cnt <= '0;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                win_cnt <= win_cnt + NWIN_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_maxpool_seq.sv
// Directed bench for maxpool_seq: table of pooling jobs plus hand-written
// backpressure, bubble, clear, reset and ignored-start sequences.
module tb_maxpool_seq;

    logic       clk, rst, start, clear;
    logic [3:0] win_len;
    logic [7:0] num_win;
    logic       in_valid, in_ready;
    logic [7:0] in_data;
    logic       out_valid, out_ready;
    logic [7:0] out_data;
    logic       busy, done;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [3:0]      wl;
        logic [7:0]      nw;
        logic [0:5][7:0] d;
        logic [0:2][7:0] e;
    } vec_t;

    vec_t vecs [6];

    maxpool_seq #(.DATA_W(8), .LEN_W(4), .NWIN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .win_len(win_len), .num_win(num_win),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic start_job(input logic [3:0] wl, input logic [7:0] nw);
        win_len = wl; num_win = nw; start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic feed(input logic [7:0] d);
        chk("in_ready_accum", in_ready, 1);
        in_valid = 1'b1; in_data = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic accept_last(input logic [7:0] exp);
        chk("last_out_valid", out_valid, 1);
        chk("last_out_data", out_data, exp);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("last_done_pulse", done, 1);
        chk("last_busy_low", busy, 0);
        step();
        chk("last_done_once", done, 0);
    endtask

    task automatic run_job(input vec_t v);
        int el, en;
        el = (v.wl == 0) ? 1 : int'(v.wl);
        en = (v.nw == 0) ? 1 : int'(v.nw);
        start_job(v.wl, v.nw);
        for (int w = 0; w < en; w++) begin
            for (int b = 0; b < el; b++) feed(v.d[w*el+b]);
            chk("out_valid_latency", out_valid, 1);
            chk("out_data", out_data, v.e[w]);
            chk("in_ready_in_out", in_ready, 0);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk("out_valid_drop", out_valid, 0);
            chk("done_pulse", done, (w == en-1) ? 1 : 0);
            chk("busy_tail", busy, (w == en-1) ? 0 : 1);
        end
        step();
        chk("done_once", done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:5]      bub_v;
        logic [0:5][7:0] bub_d;

        vecs[0] = '{4'd4, 8'd1, {8'd3, 8'd9, 8'd2, 8'd7, 8'd0, 8'd0},       {8'd9, 8'd0, 8'd0}};
        vecs[1] = '{4'd2, 8'd3, {8'd5, 8'd1, 8'd0, 8'd0, 8'd200, 8'd201},   {8'd5, 8'd0, 8'd201}};
        vecs[2] = '{4'd0, 8'd0, {8'd42, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},      {8'd42, 8'd0, 8'd0}};
        vecs[3] = '{4'd3, 8'd2, {8'd1, 8'd2, 8'd3, 8'd9, 8'd9, 8'd0},       {8'd3, 8'd9, 8'd0}};
        vecs[4] = '{4'd1, 8'd3, {8'd7, 8'd0, 8'd128, 8'd0, 8'd0, 8'd0},     {8'd7, 8'd0, 8'd128}};
        vecs[5] = '{4'd5, 8'd1, {8'd255, 8'd0, 8'd254, 8'd255, 8'd1, 8'd0}, {8'd255, 8'd0, 8'd0}};

        clk = 0; rst = 0; start = 0; clear = 0; win_len = 0; num_win = 0;
        in_valid = 0; in_data = 0; out_ready = 0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        step();
        rst = 1;
        step();

        for (int i = 0; i < 6; i++) run_job(vecs[i]);

        // Backpressure: result held, no beats accepted even with in_valid asserted.
        start_job(4'd3, 8'd1);
        feed(8'd4); feed(8'd4); feed(8'd4);
        in_valid = 1'b1; in_data = 8'd250;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data", out_data, 4);
            chk("bp_in_ready", in_ready, 0);
            step();
        end
        in_valid = 1'b0;
        accept_last(8'd4);

        // Bubbles: idle cycles must not advance the element counter.
        bub_v = 6'b100101;
        bub_d = {8'd8, 8'd250, 8'd250, 8'd255, 8'd250, 8'd6};
        start_job(4'd3, 8'd1);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) chk("bubble_no_early", out_valid, 0);
            in_valid = bub_v[i]; in_data = bub_d[i];
            step();
        end
        in_valid = 1'b0;
        accept_last(8'd255);

        // Clear mid-window, then clear+start in IDLE, then a fresh job.
        start_job(4'd4, 8'd1);
        feed(8'd10); feed(8'd20);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_busy", busy, 0);
        chk("clr_in_ready", in_ready, 0);
        chk("clr_out_valid", out_valid, 0);
        chk("clr_done", done, 0);
        step();
        chk("clr_done_later", done, 0);
        win_len = 4'd1; num_win = 8'd1; start = 1'b1; clear = 1'b1;
        step();
        start = 1'b0; clear = 1'b0;
        chk("clr_start_busy", busy, 0);
        chk("clr_start_in_ready", in_ready, 0);
        start_job(4'd1, 8'd1);
        feed(8'd3);
        accept_last(8'd3);

        // Asynchronous reset mid-window.
        start_job(4'd4, 8'd2);
        feed(8'd50); feed(8'd60);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_done", done, 0);
        step();
        rst = 1'b1;
        step();
        chk("arst_done_after", done, 0);
        chk("arst_busy_after", busy, 0);

        // Start while busy must not relatch the window length or restart the count.
        start_job(4'd2, 8'd1);
        feed(8'd40);
        win_len = 4'd1; num_win = 8'd5; start = 1'b1;
        step();
        start = 1'b0;
        chk("ign_start_busy", busy, 1);
        chk("ign_start_in_ready", in_ready, 1);
        feed(8'd30);
        accept_last(8'd40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/maxpool_seq.md
Name: maxpool_seq

Overview:
- Sequencer for the running-max pooling datapath of the accelerator.
- Accepts one pooling job: window length and window count, latched on start.
- Streams feature values in over a valid/ready handshake, clears the max accumulator at each window start, and emits one max per window over a valid/ready handshake.
- Sits between the activation buffer read port and the pooled-output writer.

Parameters:
- DATA_W, 8, width of feature values (unsigned).
- LEN_W, 4, width of window-length field; max window length 2^LEN_W-1.
- NWIN_W, 8, width of window-count field.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  job start pulse; honoured only in IDLE.
- clear  input  1  synchronous abort; highest priority after reset.
- win_len  input  LEN_W  elements per window, sampled on accepted start.
- num_win  input  NWIN_W  windows per job, sampled on accepted start.
- in_valid  input  1  in_data valid.
- in_ready  output  1  sequencer accepts in_data this cycle.
- in_data  input  DATA_W  feature value.
- out_valid  output  1  out_data holds a pooled result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  DATA_W  window maximum.
- busy  output  1  job in progress.
- done  output  1  one-cycle pulse after last result accepted.

Behaviour:
- Reset (rst=0, async): state IDLE, acc=0, elem_cnt=0, win_cnt=0, out_valid=0, out_data=0, busy=0, done=0. in_ready=0 follows from the IDLE state.
- FSM states: IDLE, ACCUM, OUT. in_ready = (state==ACCUM), combinational from state only.
- IDLE: on start=1, latch len_r=win_len and nwin_r=num_win, with 0 substituted by 1 for either field. Then elem_cnt=0, win_cnt=0, busy<=1, go to ACCUM. done is 0 except for its pulse.
- ACCUM: a beat transfers when in_valid&in_ready.
  - First beat of a window (elem_cnt==0): acc<=in_data. The accumulator loads and never compares against a stale value.
  - Other beats: acc<=(in_data>acc)?in_data:acc. Ties keep acc.
  - elem_cnt increments per transferred beat.
  - On the beat with elem_cnt==len_r-1: out_data<=max(acc,in_data), or in_data if len_r==1. Also out_valid<=1, elem_cnt<=0, go to OUT.
  - Latency: out_valid rises the cycle after the last beat transfers.
  - No beat transfers in cycles with in_valid=0; counters hold.
- OUT: in_ready=0. out_data and out_valid are held stable while out_ready=0.
  - On out_ready=1: out_valid<=0 and win_cnt increments.
  - If win_cnt==nwin_r-1: go to IDLE, busy<=0, done<=1 for exactly one cycle.
  - Otherwise return to ACCUM for the next window. There is no bubble beyond the one OUT cycle.
- start is ignored outside IDLE; latched config is unaffected.
- clear=1 in any state: go to IDLE next edge, out_valid<=0, busy<=0, counters<=0, acc<=0, done stays 0. Any partially accumulated window is discarded.
- clear together with start in IDLE: clear wins; the job does not start.
- Reset asserted mid-job: all state returns immediately to reset values; no done pulse.
- Counters never wrap: elem_cnt is bounded by len_r-1 and win_cnt by nwin_r-1.

Test Plan:
- Reset then start, win_len=4, num_win=1, stream 3,9,2,7 with in_valid held 1 -> out_valid=1 one cycle after the 4th beat, out_data=9. After out_ready, done pulses for one cycle and busy=0.
- win_len=2, num_win=3, stream 5,1 | 0,0 | 200,201 with out_ready=1 -> outputs 5, 0, 201 in order. The second window yields 0, proving acc reload; done follows the third result.
- Backpressure: win_len=3, data 4,4,4, out_ready=0 for 5 cycles -> out_valid and out_data=4 held, in_ready=0 throughout. The result is accepted when out_ready rises.
- Bubbles: win_len=3, in_valid toggling 1,0,0,1,0,1 with data 8,x,x,255,x,6 -> out_data=255. Counters do not advance on idle cycles.
- win_len=0 and num_win=0 at start, single beat 42 -> treated as 1/1: out_data=42, then done.
- Aborts:
  - clear after 2 of 4 beats -> IDLE, busy=0, no done. A new job with win_len=1, data 3 then yields 3.
  - rst pulse low mid-window -> immediate reset values.
  - start pulsed while busy -> ignored.
